// File: rtl/wb_arbiter2_rr.sv
// wb_arbiter2_rr
// Two-master Wishbone B4 classic arbiter with round-robin priority, a grant
// that stays locked for the whole cyc cycle, and a bus-timeout watchdog that
// terminates hung accesses with err.
//
// Ports:
//   wb_clk, wb_rst_n          clock, asynchronous active-low reset
//   wbm0_* / wbm1_*           master-side Wishbone ports (inputs from masters,
//                             dat/ack/err/rty back to masters)
//   wbs_*                     slave-side Wishbone port (granted master's copy)
//   grant_o                   one-hot current grant, 2'b00 when idle
//   timeout_o                 one-cycle pulse when the watchdog fires
module wb_arbiter2_rr #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    // master 0
    input  logic [AW-1:0]   wbm0_adr_i,
    input  logic [DW-1:0]   wbm0_dat_i,
    input  logic [DW/8-1:0] wbm0_sel_i,
    input  logic            wbm0_we_i,
    input  logic            wbm0_cyc_i,
    input  logic            wbm0_stb_i,
    input  logic [2:0]      wbm0_cti_i,
    input  logic [1:0]      wbm0_bte_i,
    output logic [DW-1:0]   wbm0_dat_o,
    output logic            wbm0_ack_o,
    output logic            wbm0_err_o,
    output logic            wbm0_rty_o,
    // master 1
    input  logic [AW-1:0]   wbm1_adr_i,
    input  logic [DW-1:0]   wbm1_dat_i,
    input  logic [DW/8-1:0] wbm1_sel_i,
    input  logic            wbm1_we_i,
    input  logic            wbm1_cyc_i,
    input  logic            wbm1_stb_i,
    input  logic [2:0]      wbm1_cti_i,
    input  logic [1:0]      wbm1_bte_i,
    output logic [DW-1:0]   wbm1_dat_o,
    output logic            wbm1_ack_o,
    output logic            wbm1_err_o,
    output logic            wbm1_rty_o,
    // slave
    output logic [AW-1:0]   wbs_adr_o,
    output logic [DW-1:0]   wbs_dat_o,
    output logic [DW/8-1:0] wbs_sel_o,
    output logic            wbs_we_o,
    output logic            wbs_cyc_o,
    output logic            wbs_stb_o,
    output logic [2:0]      wbs_cti_o,
    output logic [1:0]      wbs_bte_o,
    input  logic [DW-1:0]   wbs_dat_i,
    input  logic            wbs_ack_i,
    input  logic            wbs_err_i,
    input  logic            wbs_rty_i,
    // status
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   last;          // most recently granted master (0 or 1)

    logic   granted;
    logic   term;
    logic   wd_fire;
    logic   cyc_mux;
    logic   stb_mux;

    // ---------------- state and round-robin pointer ----------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
            last  <= 1'b1;     // m0 wins the first contention after reset
        end else begin
            state <= state_nxt;
            if (state == GNT0 && state_nxt != GNT0) begin
                last <= 1'b0;
            end else if (state == GNT1 && state_nxt != GNT1) begin
                last <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wbm0_cyc_i && wbm1_cyc_i) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (wbm0_cyc_i) begin
                    state_nxt = GNT0;
                end else if (wbm1_cyc_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!wbm0_cyc_i) begin
                    state_nxt = wbm1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!wbm1_cyc_i) begin
                    state_nxt = wbm0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- slave-side mux ----------------
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        cyc_mux   = 1'b0;
        stb_mux   = 1'b0;
        case (state)
            GNT0: begin
                wbs_adr_o = wbm0_adr_i;
                wbs_dat_o = wbm0_dat_i;
                wbs_sel_o = wbm0_sel_i;
                wbs_we_o  = wbm0_we_i;
                wbs_cti_o = wbm0_cti_i;
                wbs_bte_o = wbm0_bte_i;
                cyc_mux   = wbm0_cyc_i;
                stb_mux   = wbm0_stb_i;
            end
            GNT1: begin
                wbs_adr_o = wbm1_adr_i;
                wbs_dat_o = wbm1_dat_i;
                wbs_sel_o = wbm1_sel_i;
                wbs_we_o  = wbm1_we_i;
                wbs_cti_o = wbm1_cti_i;
                wbs_bte_o = wbm1_bte_i;
                cyc_mux   = wbm1_cyc_i;
                stb_mux   = wbm1_stb_i;
            end
            default: ;
        endcase
    end

    // A firing watchdog withdraws the access from the slave in the same cycle
    // the err is handed back, so a late slave ack cannot land on a dead cycle.
    assign wbs_cyc_o = cyc_mux & ~wd_fire;
    assign wbs_stb_o = stb_mux & ~wd_fire;

    assign granted   = (state == GNT0) || (state == GNT1);
    assign term      = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign grant_o   = {state == GNT1, state == GNT0};
    assign timeout_o = wd_fire;

    // ---------------- response routing ----------------
    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

    assign wbm0_ack_o = (state == GNT0) & wbs_ack_i & ~wd_fire;
    assign wbm0_rty_o = (state == GNT0) & wbs_rty_i & ~wd_fire;
    assign wbm0_err_o = (state == GNT0) & (wbs_err_i | wd_fire);
    assign wbm1_ack_o = (state == GNT1) & wbs_ack_i & ~wd_fire;
    assign wbm1_rty_o = (state == GNT1) & wbs_rty_i & ~wd_fire;
    assign wbm1_err_o = (state == GNT1) & (wbs_err_i | wd_fire);

    // ---------------- watchdog ----------------
    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW_RAW = $clog2(TIMEOUT + 1);
            localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);
            localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

            logic [CW-1:0] wd_cnt;

            // The first visible stb cycle sees a count of 0, so the count
            // reaches TIMEOUT in stb cycle TIMEOUT+1.
            assign wd_fire = granted & cyc_mux & stb_mux & (wd_cnt == TO_VAL);

            always_ff @(posedge wb_clk or negedge wb_rst_n) begin
                if (!wb_rst_n) begin
                    wd_cnt <= '0;
                end else if (!granted || term || wd_fire || (state_nxt != state)) begin
                    wd_cnt <= '0;
                end else if (cyc_mux && stb_mux) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end else begin : g_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

endmodule

// File: doc/wb_arbiter2_rr.md
# wb_arbiter2_rr

Two-master Wishbone B4 classic arbiter placed between the RISC-V core's master port and the SoC interconnect, so a second master (DMA or debug loader) can share the single bus into ram0, gpio0 and timer0. Round-robin arbitration with bus lock for the whole `cyc` cycle. A bus-timeout watchdog terminates hung slave accesses with `err`, so the CPU is never stalled forever.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; select width is `DW/8`.
- `TIMEOUT`, 255, cycles of unanswered `stb` before the arbiter returns `err`; 0 disables the watchdog.

Ports (x = 0,1):
- `wb_clk`  in  1  bus clock; all logic on its rising edge.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `wbm{x}_adr_i`  in  AW  master x address.
- `wbm{x}_dat_i`  in  DW  master x write data.
- `wbm{x}_sel_i`  in  DW/8  master x byte select.
- `wbm{x}_we_i`, `wbm{x}_cyc_i`, `wbm{x}_stb_i`  in  1 each  master x control.
- `wbm{x}_cti_i`  in  3  master x cycle type.
- `wbm{x}_bte_i`  in  2  master x burst type.
- `wbm{x}_dat_o`  out  DW  read data; the slave's `wbs_dat_i` passed to both masters.
- `wbm{x}_ack_o`, `wbm{x}_err_o`, `wbm{x}_rty_o`  out  1 each  termination, valid only for the granted master.
- `wbs_adr_o`, `wbs_dat_o`, `wbs_sel_o`, `wbs_we_o`, `wbs_cyc_o`, `wbs_stb_o`, `wbs_cti_o`, `wbs_bte_o`  out  slave-side copies of the granted master's signals.
- `wbs_dat_i`, `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i`  in  slave response.
- `grant_o`  out  2  one-hot current grant; 2'b00 when idle.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, GNT0, GNT1. Registered `last` pointer records the most recently granted master.
- IDLE: only m0 `cyc` -> GNT0. Only m1 `cyc` -> GNT1. Both -> grant the master not equal to `last`. Neither -> stay in IDLE.
- GNTx: hold while `wbmx_cyc_i`=1, so the grant is locked for RMW and bursts. When `cyc` drops, go to GNTy if the other master has `cyc`=1, otherwise go to IDLE. `last` <= x on leaving GNTx.
- Slave-side mux is combinational from the registered state. In IDLE all `wbs_*_o` are 0. In GNTx `wbs_*_o` equal master x inputs.
- `wbs_ack/err/rty_i` are routed only to the granted master; the non-granted master sees 0.
- Watchdog: 8..32-bit counter sized by `$clog2(TIMEOUT+1)`.
  - Counts while granted, `wbs_cyc_o & wbs_stb_o`, and no ack/err/rty.
  - Clears on any termination, on a grant change, or in IDLE.
  - When the count equals `TIMEOUT`, in that cycle: `wbmx_err_o`=1, `wbs_cyc_o`/`wbs_stb_o` forced to 0, `timeout_o`=1, counter clears.
- `TIMEOUT`=0: counter and forcing logic are removed; `timeout_o` is tied to 0.
- Reset: state IDLE, `last`=1 (m0 wins first contention), counter 0. All outputs 0 except `wbm{x}_dat_o`, which follows `wbs_dat_i`.

## Timing
- Grant latency is 1 cycle from `cyc` rising in IDLE: first slave `stb` appears the cycle after the master raises `cyc`/`stb`.
- Handover is 1 cycle. Master x drops `cyc` in cycle n. If y is waiting, `wbs_*` carry y in cycle n+1, with no IDLE bubble.
- Response path (ack/err/rty/dat) is combinational: zero added latency once granted. Single-cycle-ack slaves still complete one transfer per cycle in bursts.
- Simultaneous release by x and request by y in the same cycle -> GNTy next cycle.
- Master dropping `cyc` in the same cycle as the slave `ack`: the ack is delivered and the grant is released at that edge.
- Watchdog fires on cycle TIMEOUT+1 after `stb` became visible at the slave, counting that first cycle as 1.
- Async reset mid-transfer: `wbs_cyc_o`/`wbs_stb_o` drop immediately and no termination is issued.

## Test plan
- Single master: m0 writes 0xDEADBEEF to 0x10 with a 1-cycle-ack slave -> `grant_o`=01 one cycle after `cyc`; slave sees adr 0x10 and data 0xDEADBEEF; m0 ack in the same cycle as slave ack; m1 ack stays 0.
- Contention after reset: both raise `cyc` in the same cycle -> GNT0 first. On m0 release, GNT1 in the next cycle. Both request again -> GNT0 (alternation holds over 8 rounds).
- Lock: m0 runs a 4-beat burst (cti 010, then 111) while m1 requests throughout -> m1 is granted only after m0's `cyc` falls, with exactly a 1-cycle handover.
- Timeout: TIMEOUT=15, slave never acks m1 read -> m1 `err`=1 and `timeout_o`=1 in the 16th `stb` cycle; slave `cyc` is 0 that cycle; arbiter returns to IDLE when m1 drops `cyc`.
- Slave err/rty passthrough: slave returns `rty` to m0 -> m0 `rty`=1, m1 sees 0, watchdog count resets to 0.
- Reset mid-burst: assert `wb_rst_n`=0 during a GNT1 burst -> `grant_o`=00 and `wbs_cyc_o`=0 asynchronously; after release, first contention grants m0.
